// File: rtl/armdma_pkg.sv
// Shared definitions for the ARM-controlled Unibus block-DMA master:
// engine states, ARM register map, ID word and Unibus cycle codes.
package armdma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARB  = 3'd1,
    ST_ADDR = 3'd2,
    ST_DSKW = 3'd3,
    ST_WAIT = 3'd4,
    ST_HOLD = 3'd5,
    ST_ENDW = 3'd6,
    ST_DONE = 3'd7
  } armdma_state_t;

  localparam logic [2:0] REG_ID    = 3'd0;
  localparam logic [2:0] REG_CSR   = 3'd1;
  localparam logic [2:0] REG_COUNT = 3'd2;
  localparam logic [2:0] REG_FIFO  = 3'd3;
  localparam logic [2:0] REG_LEVEL = 3'd4;

  localparam logic [31:0] ARMDMA_ID   = 32'h444D3001;
  localparam logic [31:0] ARMDMA_NONE = 32'hDEADBEEF;

  // Unibus C-line codes, driven directly onto c_out_h
  localparam logic [1:0] CTRL_DATI  = 2'b00;
  localparam logic [1:0] CTRL_DATO  = 2'b10;
  localparam logic [1:0] CTRL_DATOB = 2'b11;

  // Byte transfers step by one, word transfers by two; wraps at 2^18
  function automatic logic [17:0] next_addr(input logic [17:0] a, input logic [1:0] c);
    return a + ((c == CTRL_DATOB) ? 18'd1 : 18'd2);
  endfunction

endpackage

// File: rtl/armdma_fifo.sv
// Synchronous word FIFO between the ARM register port and the DMA engine.
// Pop of an empty FIFO is ignored; push when full is dropped unless a pop
// happens in the same cycle.
module armdma_fifo
  import armdma_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        push,
  input  logic [15:0] push_data,
  input  logic        pop,
  output logic [15:0] head,
  output logic [8:0]  level,
  output logic        empty,
  output logic        full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (level == 9'd0);
  assign full    = (level == 9'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Pointer and level bookkeeping
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 9'd1;
        2'b01:   level <= level - 9'd1;
        default: level <= level;
      endcase
    end
  end

  // Storage array
  always_ff @(posedge CLOCK) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/armdma_block.sv
// ARM-controlled Unibus block-DMA master: runs a block of DATI/DATO/DATOB
// cycles while holding BBSY, moving data through armdma_fifo.
// Optional build macro ARMDMA_IRQ_EN adds irq_out (CSR[23] mirrors it).
module armdma_block
  import armdma_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int TOUT   = 1023,
  parameter int DESKEW = 15,
  parameter int GNTDLY = 4
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        armwrite,
  input  logic        armread,
  input  logic [2:0]  armraddr,
  input  logic [2:0]  armwaddr,
  input  logic [31:0] armwdata,
  output logic [31:0] armrdata,
  input  logic [17:0] a_in_h,
  input  logic [1:0]  c_in_h,
  input  logic [15:0] d_in_h,
  input  logic        msyn_in_h,
  input  logic        ssyn_in_h,
  input  logic        init_in_h,
  input  logic        hltgr_in_l,
  input  logic        npg_in_l,
  output logic [17:0] a_out_h,
  output logic [1:0]  c_out_h,
  output logic [15:0] d_out_h,
  output logic        msyn_out_h,
  output logic        bbsy_out_h,
  output logic        npr_out_h,
  output logic        sack_out_h,
  output logic        npg_out_l
`ifdef ARMDMA_IRQ_EN
  ,
  output logic        irq_out
`endif
);

  localparam logic [15:0] TOUT_C   = 16'(TOUT);
  localparam logic [15:0] DSK_LAST = 16'(DESKEW - 1);
  localparam logic [7:0]  GNT_C    = 8'(GNTDLY);

  armdma_state_t state;
  logic          fail;
  logic          abort_req;
  logic [1:0]    ctrl;
  logic [17:0]   addr;
  logic [15:0]   count;
  logic [15:0]   cnt;
  logic [7:0]    gcnt;
  logic          busy;
  logic          grant;
  logic          irq;
  logic [31:0]   csr;

  logic          fifo_push;
  logic [15:0]   fifo_push_data;
  logic          fifo_pop;
  logic [15:0]   fifo_head;
  logic [8:0]    fifo_level;
  logic          fifo_empty;
  logic          fifo_full;
  logic          eng_push;
  logic          eng_pop;
  logic          arm_push;
  logic          arm_pop;
  logic          unused_inputs;

  assign unused_inputs = ^{a_in_h, c_in_h, msyn_in_h, armwdata};

  assign busy  = (state != ST_IDLE);
  assign grant = npr_out_h && !npg_in_l;
  assign npg_out_l = npr_out_h ? 1'b1 : npg_in_l;

  // The engine moves one word at the end of the data-hold phase
  assign eng_push = (state == ST_HOLD) && (cnt == DSK_LAST) && !ctrl[1];
  assign eng_pop  = (state == ST_HOLD) && (cnt == DSK_LAST) && ctrl[1];
  assign arm_push = armwrite && (armwaddr == REG_FIFO);
  assign arm_pop  = armread && (armraddr == REG_FIFO) && !fifo_empty;

  // Engine push wins the single write port; pops from either side merge
  assign fifo_push      = eng_push || arm_push;
  assign fifo_push_data = eng_push ? d_in_h : armwdata[15:0];
  assign fifo_pop       = eng_pop || arm_pop;

`ifdef ARMDMA_IRQ_EN
  assign irq_out = irq;
`else
  assign irq = 1'b0;
`endif

  armdma_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CLOCK     (CLOCK),
    .RESET     (RESET),
    .push      (fifo_push),
    .push_data (fifo_push_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .level     (fifo_level),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // ARM register read mux
  always_comb begin
    csr        = '0;
    csr[31:29] = state;
    csr[28]    = fail;
    csr[27:26] = ctrl;
    csr[25]    = busy;
    csr[23]    = irq;
    csr[17:0]  = addr;
    armrdata   = ARMDMA_NONE;
    case (armraddr)
      REG_ID:    armrdata = ARMDMA_ID;
      REG_CSR:   armrdata = csr;
      REG_COUNT: armrdata = {16'd0, count};
      REG_FIFO:  armrdata = fifo_empty ? 32'd0 : {16'd0, fifo_head};
      REG_LEVEL: armrdata = {23'd0, fifo_level};
      default:   armrdata = ARMDMA_NONE;
    endcase
  end

  // Register writes and the bus-cycle sequencer
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state      <= ST_IDLE;
      fail       <= 1'b0;
      abort_req  <= 1'b0;
      ctrl       <= '0;
      addr       <= '0;
      count      <= '0;
      cnt        <= '0;
      gcnt       <= '0;
      a_out_h    <= '0;
      c_out_h    <= '0;
      d_out_h    <= '0;
      msyn_out_h <= 1'b0;
      bbsy_out_h <= 1'b0;
      npr_out_h  <= 1'b0;
      sack_out_h <= 1'b0;
`ifdef ARMDMA_IRQ_EN
      irq        <= 1'b0;
`endif
    end else if (init_in_h) begin
      if (busy) fail <= 1'b1;
      state      <= ST_IDLE;
      abort_req  <= 1'b0;
      cnt        <= '0;
      gcnt       <= '0;
      a_out_h    <= '0;
      c_out_h    <= '0;
      d_out_h    <= '0;
      msyn_out_h <= 1'b0;
      bbsy_out_h <= 1'b0;
      npr_out_h  <= 1'b0;
      sack_out_h <= 1'b0;
    end else begin
      if (armwrite && armwaddr == REG_CSR) begin
`ifdef ARMDMA_IRQ_EN
        irq <= 1'b0;
`endif
        if (!busy) begin
          if (armwdata[29] && count != 16'd0) begin
            addr      <= armwdata[17:0];
            ctrl      <= armwdata[27:26];
            fail      <= 1'b0;
            abort_req <= 1'b0;
            cnt       <= '0;
            gcnt      <= '0;
            state     <= ST_ARB;
          end
        end else if (armwdata[24]) begin
          abort_req <= 1'b1;
        end
      end
      if (armwrite && armwaddr == REG_COUNT && !busy) count <= armwdata[15:0];

      case (state)
        ST_ARB: begin
          if (!hltgr_in_l || (grant && gcnt == GNT_C)) begin
            bbsy_out_h <= 1'b1;
            sack_out_h <= 1'b1;
            npr_out_h  <= 1'b0;
            gcnt       <= '0;
            cnt        <= '0;
            state      <= ST_ADDR;
          end else begin
            if (npg_in_l) npr_out_h <= 1'b1;
            gcnt <= grant ? gcnt + 8'd1 : 8'd0;
          end
        end
        ST_ADDR: begin
          a_out_h <= addr;
          c_out_h <= ctrl;
          d_out_h <= (ctrl[1] && !fifo_empty) ? fifo_head : 16'd0;
          if (ctrl[1]) begin
            if (fifo_empty) begin
              if (cnt == TOUT_C) begin
                fail  <= 1'b1;
                cnt   <= '0;
                state <= ST_DONE;
              end else begin
                cnt <= cnt + 16'd1;
              end
            end else begin
              cnt   <= '0;
              state <= ST_DSKW;
            end
          end else if (!fifo_full) begin
            cnt   <= '0;
            state <= ST_DSKW;
          end
        end
        ST_DSKW: begin
          if (cnt == DSK_LAST) begin
            msyn_out_h <= 1'b1;
            cnt        <= '0;
            state      <= ST_WAIT;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ST_WAIT: begin
          if (ssyn_in_h) begin
            cnt   <= '0;
            state <= ST_HOLD;
          end else if (cnt == TOUT_C) begin
            fail       <= 1'b1;
            msyn_out_h <= 1'b0;
            cnt        <= '0;
            state      <= ST_DONE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ST_HOLD: begin
          if (cnt == DSK_LAST) begin
            msyn_out_h <= 1'b0;
            addr       <= next_addr(addr, ctrl);
            count      <= count - 16'd1;
            cnt        <= '0;
            state      <= ST_ENDW;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ST_ENDW: begin
          if (cnt == DSK_LAST) begin
            cnt   <= '0;
            state <= (count != 16'd0 && !abort_req) ? ST_ADDR : ST_DONE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ST_DONE: begin
          a_out_h    <= '0;
          c_out_h    <= '0;
          d_out_h    <= '0;
          msyn_out_h <= 1'b0;
          bbsy_out_h <= 1'b0;
          sack_out_h <= 1'b0;
          npr_out_h  <= 1'b0;
          abort_req  <= 1'b0;
`ifdef ARMDMA_IRQ_EN
          irq        <= 1'b1;
`endif
          state      <= ST_IDLE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_armdma_block.sv
// Directed bench for armdma_block: register table, FIFO corners and
// multi-cycle Unibus block transfers against a simple SSYN responder.
module tb_armdma_block;
  import armdma_pkg::*;

  logic        CLOCK = 0;
  logic        RESET;
  logic        armwrite, armread;
  logic [2:0]  armraddr, armwaddr;
  logic [31:0] armwdata, armrdata;
  logic [17:0] a_in_h, a_out_h;
  logic [1:0]  c_in_h, c_out_h;
  logic [15:0] d_in_h, d_out_h;
  logic        msyn_in_h, ssyn_in_h, init_in_h, hltgr_in_l, npg_in_l;
  logic        msyn_out_h, bbsy_out_h, npr_out_h, sack_out_h, npg_out_l;
`ifdef ARMDMA_IRQ_EN
  logic        irq_out;
`endif

  int nchk = 0;
  int nerr = 0;

  logic        slave_en = 0;
  logic [17:0] log_a[$];
  logic [1:0]  log_c[$];
  logic [15:0] log_d[$];
  int          bbsy_falls = 0;
  int          msyn_rises = 0;
  int          msyn_nobbsy = 0;

  always #5 CLOCK = ~CLOCK;

  armdma_block #(.DEPTH(16), .TOUT(1023), .DESKEW(15), .GNTDLY(4)) dut (
    .CLOCK(CLOCK), .RESET(RESET),
    .armwrite(armwrite), .armread(armread), .armraddr(armraddr), .armwaddr(armwaddr),
    .armwdata(armwdata), .armrdata(armrdata),
    .a_in_h(a_in_h), .c_in_h(c_in_h), .d_in_h(d_in_h), .msyn_in_h(msyn_in_h),
    .ssyn_in_h(ssyn_in_h), .init_in_h(init_in_h), .hltgr_in_l(hltgr_in_l), .npg_in_l(npg_in_l),
    .a_out_h(a_out_h), .c_out_h(c_out_h), .d_out_h(d_out_h), .msyn_out_h(msyn_out_h),
    .bbsy_out_h(bbsy_out_h), .npr_out_h(npr_out_h), .sack_out_h(sack_out_h), .npg_out_l(npg_out_l)
`ifdef ARMDMA_IRQ_EN
    , .irq_out(irq_out)
`endif
  );

  function automatic logic [15:0] slave_data(input logic [17:0] a);
    return a[15:0] ^ 16'h5A5A;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Unibus slave: answers MSYN with SSYN, logs each cycle, supplies read data
  initial begin
    ssyn_in_h = 0;
    d_in_h    = '0;
    forever begin
      @(negedge CLOCK);
      if (slave_en && msyn_out_h && !ssyn_in_h) begin
        log_a.push_back(a_out_h);
        log_c.push_back(c_out_h);
        log_d.push_back(d_out_h);
        d_in_h    = slave_data(a_out_h);
        ssyn_in_h = 1;
      end else if (!msyn_out_h) begin
        ssyn_in_h = 0;
      end
    end
  end

  // Bus activity monitor
  initial begin
    logic pb, pm;
    pb = 0; pm = 0;
    forever begin
      @(posedge CLOCK); #1;
      if (pb && !bbsy_out_h) bbsy_falls++;
      if (!pm && msyn_out_h) msyn_rises++;
      if (msyn_out_h && !bbsy_out_h) msyn_nobbsy++;
      pb = bbsy_out_h;
      pm = msyn_out_h;
    end
  end

  task automatic arm_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge CLOCK);
    armwrite = 1; armwaddr = a; armwdata = d;
    @(negedge CLOCK);
    armwrite = 0;
  endtask

  task automatic arm_read(input logic [2:0] a, input logic pop, output logic [31:0] d);
    @(negedge CLOCK);
    armraddr = a; armread = pop;
    #1 d = armrdata;
    @(negedge CLOCK);
    armread = 0;
  endtask

  task automatic peek(input logic [2:0] a, output logic [31:0] d);
    armraddr = a; armread = 0;
    #1 d = armrdata;
  endtask

  task automatic start(input logic [1:0] c, input logic [17:0] a);
    arm_write(REG_CSR, 32'h2000_0000 | (32'(c) << 26) | 32'(a));
  endtask

  task automatic wait_idle(input int bound, input string nm);
    logic [31:0] v;
    int n;
    n = 0;
    peek(REG_CSR, v);
    while (v[25] && n < bound) begin
      @(negedge CLOCK);
      peek(REG_CSR, v);
      n++;
    end
    check(nm, {31'd0, v[25]}, 32'd0);
  endtask

  task automatic wait_msyn(input logic lvl, input int bound, output int n);
    n = 0;
    while (msyn_out_h !== lvl && n < bound) begin
      @(posedge CLOCK); #1;
      n++;
    end
  endtask

  typedef struct {
    logic        wr;
    logic [2:0]  waddr;
    logic [31:0] wdata;
    logic [2:0]  raddr;
    logic        rd;
    logic [31:0] exp;
    string       nm;
  } vec_t;

  vec_t vq[$];

  initial begin
    logic [31:0] v, v2;
    int n, b0, f0, m0;

    RESET = 1; armwrite = 0; armread = 0; armraddr = 0; armwaddr = 0; armwdata = 0;
    a_in_h = 0; c_in_h = 0; msyn_in_h = 0; init_in_h = 0; hltgr_in_l = 1; npg_in_l = 1;
    repeat (3) @(negedge CLOCK);
    RESET = 0;
    #1;
    check("reset_bus", {a_out_h, c_out_h, d_out_h, msyn_out_h, bbsy_out_h, npr_out_h, sack_out_h},
          '0);
    check("reset_npg_pass", {31'd0, npg_out_l}, 32'd1);

    // Register-level vectors
    vq.push_back('{0, 0, 0, REG_ID, 0, ARMDMA_ID, "id"});
    vq.push_back('{0, 0, 0, 3'd5, 0, 32'hDEADBEEF, "reg5"});
    vq.push_back('{0, 0, 0, 3'd7, 0, 32'hDEADBEEF, "reg7"});
    vq.push_back('{0, 0, 0, REG_CSR, 0, 32'h0, "csr_reset"});
    vq.push_back('{0, 0, 0, REG_FIFO, 1, 32'h0, "pop_empty"});
    vq.push_back('{0, 0, 0, REG_LEVEL, 0, 32'h0, "level_empty"});
    vq.push_back('{1, REG_COUNT, 32'h0001_2345, REG_COUNT, 0, 32'h2345, "count_wr"});
    vq.push_back('{1, REG_FIFO, 32'hCAFE_1234, REG_LEVEL, 0, 32'd1, "push1"});
    vq.push_back('{1, REG_FIFO, 32'h0000_5678, REG_LEVEL, 0, 32'd2, "push2"});
    vq.push_back('{0, 0, 0, REG_FIFO, 1, 32'h1234, "pop1"});
    vq.push_back('{0, 0, 0, REG_LEVEL, 0, 32'd1, "level_after_pop"});
    vq.push_back('{0, 0, 0, REG_FIFO, 1, 32'h5678, "pop2"});
    vq.push_back('{0, 0, 0, REG_FIFO, 1, 32'h0, "pop_empty2"});
    vq.push_back('{1, REG_COUNT, 32'h0, REG_COUNT, 0, 32'h0, "count_zero"});
    vq.push_back('{1, REG_CSR, 32'h2800_029C, REG_CSR, 0, 32'h0, "start_count0"});
    vq.push_back('{1, REG_COUNT, 32'h1, REG_COUNT, 0, 32'h1, "count_one"});
    foreach (vq[i]) begin
      if (vq[i].wr) arm_write(vq[i].waddr, vq[i].wdata);
      arm_read(vq[i].raddr, vq[i].rd, v);
      check(vq[i].nm, v, vq[i].exp);
    end

    // FIFO full: overflow drops, simultaneous push+pop keeps level
    for (int i = 0; i < 17; i++) arm_write(REG_FIFO, 32'h100 + 32'(i));
    arm_read(REG_LEVEL, 0, v);
    check("fifo_sat", v, 32'd16);
    @(negedge CLOCK);
    armwrite = 1; armwaddr = REG_FIFO; armwdata = 32'h1FF;
    armread = 1; armraddr = REG_FIFO;
    #1 v = armrdata;
    @(negedge CLOCK);
    armwrite = 0; armread = 0;
    check("fifo_pushpop_data", v, 32'h100);
    arm_read(REG_LEVEL, 0, v);
    check("fifo_pushpop_level", v, 32'd16);
    arm_read(REG_FIFO, 1, v);
    check("fifo_order_first", v, 32'h101);
    for (int i = 0; i < 14; i++) arm_read(REG_FIFO, 1, v);
    arm_read(REG_FIFO, 1, v);
    check("fifo_order_last", v, 32'h1FF);
    arm_read(REG_LEVEL, 0, v);
    check("fifo_drained", v, 32'd0);

    // Halted CPU, DATO of 1,2,3 at 1000
    slave_en = 1; hltgr_in_l = 0;
    arm_write(REG_FIFO, 1); arm_write(REG_FIFO, 2); arm_write(REG_FIFO, 3);
    arm_write(REG_COUNT, 3);
    b0 = bbsy_falls; f0 = log_a.size();
    start(CTRL_DATO, 18'o1000);
    wait_idle(2000, "s1_done");
    check("s1_ncycles", 32'(log_a.size() - f0), 32'd3);
    if (log_a.size() >= f0 + 3) begin
      for (int i = 0; i < 3; i++) begin
        check("s1_addr", 32'(log_a[f0+i]), 32'(18'o1000 + 18'(2*i)));
        check("s1_c", 32'(log_c[f0+i]), 32'(CTRL_DATO));
        check("s1_data", 32'(log_d[f0+i]), 32'(i + 1));
      end
    end
    check("s1_bbsy_once", 32'(bbsy_falls - b0), 32'd1);
    check("s1_msyn_bbsy", 32'(msyn_nobbsy), 32'd0);
    arm_read(REG_COUNT, 0, v);  check("s1_count", v, 32'd0);
    arm_read(REG_LEVEL, 0, v);  check("s1_level", v, 32'd0);
    arm_read(REG_CSR, 0, v);    check("s1_csr", v & ~32'h0080_0000, 32'h0800_0206);

    // NPR path, DATI at 777776 wrapping to 0
    hltgr_in_l = 1; npg_in_l = 1;
    arm_write(REG_COUNT, 2);
    f0 = log_a.size();
    start(CTRL_DATI, 18'o777776);
    n = 0;
    while (!npr_out_h && n < 20) begin @(posedge CLOCK); #1; n++; end
    check("s2_npr", {31'd0, npr_out_h}, 32'd1);
    @(negedge CLOCK);
    npg_in_l = 0;
    #1 check("s2_npg_blocked", {31'd0, npg_out_l}, 32'd1);
    n = 0;
    while (!bbsy_out_h && n < 20) begin @(posedge CLOCK); #1; n++; end
    check("s2_grant_delay", 32'(n), 32'd5);
    check("s2_sack_npr", {30'd0, sack_out_h, npr_out_h}, 32'b10);
    @(negedge CLOCK);
    npg_in_l = 1;
    wait_idle(2000, "s2_done");
    check("s2_ncycles", 32'(log_a.size() - f0), 32'd2);
    if (log_a.size() >= f0 + 2) begin
      check("s2_addr0", 32'(log_a[f0]), 32'(18'o777776));
      check("s2_addr1", 32'(log_a[f0+1]), 32'd0);
      check("s2_c", 32'(log_c[f0]), 32'(CTRL_DATI));
    end
    arm_read(REG_LEVEL, 0, v);  check("s2_level", v, 32'd2);
    arm_read(REG_FIFO, 1, v);   check("s2_rd0", v, 32'hA5A4);
    arm_read(REG_FIFO, 1, v);   check("s2_rd1", v, 32'h5A5A);
    arm_read(REG_CSR, 0, v);    check("s2_csr", v & ~32'h0080_0000, 32'h0000_0002);

    // No SSYN responder: timeout
    slave_en = 0; hltgr_in_l = 0;
    arm_write(REG_COUNT, 2);
    start(CTRL_DATI, 18'o2000);
    wait_msyn(1, 100, n);
    check("s3_msyn_up", {31'd0, msyn_out_h}, 32'd1);
    wait_msyn(0, 1100, n);
    check("s3_tout_len", 32'(n), 32'd1024);
    wait_idle(100, "s3_done");
    arm_read(REG_CSR, 0, v);    check("s3_csr", v & ~32'h0080_0000, 32'h1000_0400);
    arm_read(REG_COUNT, 0, v);  check("s3_count", v, 32'd2);

    // Abort during word 2 of 5; busy writes to count and start ignored
    slave_en = 1;
    arm_write(REG_COUNT, 5);
    f0 = log_a.size();
    start(CTRL_DATI, 18'o3000);
    n = 0;
    while (log_a.size() < f0 + 2 && n < 500) begin @(negedge CLOCK); n++; end
    check("s4_word2", 32'(log_a.size() - f0), 32'd2);
    arm_write(REG_COUNT, 7);
    arm_write(REG_CSR, 32'h2100_0000);
    wait_idle(500, "s4_done");
    check("s4_ncycles", 32'(log_a.size() - f0), 32'd2);
    check("s4_released", {a_out_h, bbsy_out_h, sack_out_h, msyn_out_h}, '0);
    arm_read(REG_COUNT, 0, v);  check("s4_count", v, 32'd3);
    arm_read(REG_CSR, 0, v);    check("s4_csr", v & ~32'h0080_0000, 32'h0000_0604);

    // INIT during WAIT
    slave_en = 0;
    arm_write(REG_COUNT, 1);
    start(CTRL_DATI, 18'o4000);
    wait_msyn(1, 100, n);
    repeat (5) @(posedge CLOCK);
    @(negedge CLOCK);
    init_in_h = 1;
    @(posedge CLOCK); #1;
    check("s5_init_bus", {a_out_h, c_out_h, d_out_h, msyn_out_h, bbsy_out_h, sack_out_h, npr_out_h},
          '0);
    @(negedge CLOCK);
    init_in_h = 0;
    arm_read(REG_CSR, 0, v);    check("s5_csr", v & ~32'h0080_0000, 32'h1000_0800);
    arm_read(REG_LEVEL, 0, v);  check("s5_fifo_kept", v, 32'd2);
    arm_read(REG_FIFO, 1, v);   check("s5_rd0", v, 32'h5C5A);
    arm_read(REG_FIFO, 1, v);   check("s5_rd1", v, 32'h5C58);

    // DATO with empty FIFO: fails after the timeout, no MSYN
    slave_en = 1;
    m0 = msyn_rises;
    arm_write(REG_COUNT, 1);
    start(CTRL_DATO, 18'o5000);
    repeat (1000) @(posedge CLOCK);
    @(negedge CLOCK);
    peek(REG_CSR, v);
    check("s6_still_waiting", {31'd0, v[25]}, 32'd1);
    wait_idle(200, "s6_done");
    check("s6_no_msyn", 32'(msyn_rises - m0), 32'd0);
    arm_read(REG_CSR, 0, v);    check("s6_csr", v & ~32'h0080_0000, 32'h1800_0A00);
    arm_read(REG_COUNT, 0, v);  check("s6_count", v, 32'd1);

    // DATOB at odd address
    arm_write(REG_FIFO, 32'h00FF);
    f0 = log_a.size();
    start(CTRL_DATOB, 18'o1001);
    wait_idle(500, "s7_done");
    check("s7_ncycles", 32'(log_a.size() - f0), 32'd1);
    if (log_a.size() >= f0 + 1) begin
      check("s7_addr", 32'(log_a[f0]), 32'(18'o1001));
      check("s7_c", 32'(log_c[f0]), 32'(CTRL_DATOB));
      check("s7_data", 32'(log_d[f0]), 32'h00FF);
    end
    arm_read(REG_CSR, 0, v2);   check("s7_csr", v2 & ~32'h0080_0000, 32'h0C00_0202);
    arm_read(REG_LEVEL, 0, v);  check("s7_level", v, 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
